// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - operation codes carried on md_op_i (codes 9-15 behave as NOP)
//   - FSM state encoding (2 bits)
//   - number of radix-2 divide steps
package muldiv_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  localparam int unsigned DIV_STEPS = 32;

endpackage

// File: rtl/muldiv_unit_div.sv
// Radix-2 restoring divider datapath on unsigned magnitudes.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start              load operands and begin DIV_STEPS iterations
//   kill               abandon an in-flight division
//   dividend_mag       dividend magnitude (sampled on start)
//   divisor_mag        divisor magnitude (sampled on start)
//   quotient_mag       quotient after the current step (combinational)
//   remainder_mag      partial remainder after the current step (combinational)
//   done               high during the final step; quotient/remainder are final
module md_div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] dividend_mag,
  input  logic [31:0] divisor_mag,
  output logic [31:0] quotient_mag,
  output logic [31:0] remainder_mag,
  output logic        done
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

  logic        running;
  logic [4:0]  step;
  logic [31:0] acc;
  logic [31:0] dq;
  logic [31:0] dvs;
  logic [32:0] shifted;
  logic        fits;

  // dq starts as the dividend; each step shifts its MSB into the partial
  // remainder and a quotient bit into its LSB. A zero divisor always "fits",
  // which yields an all-ones quotient and the dividend as remainder.
  always_comb begin
    shifted       = {acc, dq[31]};
    fits          = shifted >= {1'b0, dvs};
    remainder_mag = fits ? (shifted[31:0] - dvs) : shifted[31:0];
    quotient_mag  = {dq[30:0], fits};
  end

  assign done = running && (step == LAST_STEP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      running <= 1'b0;
      step    <= '0;
      acc     <= '0;
      dq      <= '0;
      dvs     <= '0;
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
      acc     <= '0;
      dq      <= dividend_mag;
      dvs     <= divisor_mag;
    end else if (kill) begin
      running <= 1'b0;
    end else if (running) begin
      acc  <= remainder_mag;
      dq   <= quotient_mag;
      step <= step + 5'd1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the complex execute lane.
// Accepts one operation per handshake, owns HI/LO, runs MULT/MULTU with a
// fixed MUL_LAT latency and DIV/DIVU as a 32-step iterative divide.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   md_valid_i           operation offered by issue
//   md_op_i              operation code (see muldiv_pkg)
//   md_src_a_i/b_i       rs / rt operand values
//   md_rd_i              destination register for MFHI/MFLO
//   md_allowin_o         unit can accept this cycle
//   md_flush_i           exception/ERET flush, highest priority
//   ms_allowin_i         downstream accepts the current record
//   md_valid_o           record valid to downstream
//   md_result_o          MFHI/MFLO data, zero otherwise
//   md_rd_o              destination register of the record
//   md_reg_write_o       MFHI/MFLO with nonzero rd
//   md_busy_o            multiply or divide in progress
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        md_valid_i,
  input  logic [3:0]  md_op_i,
  input  logic [31:0] md_src_a_i,
  input  logic [31:0] md_src_b_i,
  input  logic [4:0]  md_rd_i,
  output logic        md_allowin_o,
  input  logic        md_flush_i,
  input  logic        ms_allowin_i,
  output logic        md_valid_o,
  output logic [31:0] md_result_o,
  output logic [4:0]  md_rd_o,
  output logic        md_reg_write_o,
  output logic        md_busy_o
);

  localparam int unsigned CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  md_state_t        state;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [CNT_W-1:0] mul_cnt;
  logic             div_neg_q;
  logic             div_neg_r;

  logic             accept;
  logic             op_mul;
  logic             op_div;
  logic             op_signed;
  logic [63:0]      mul_a;
  logic [63:0]      mul_b;
  logic [63:0]      mul_prod;
  logic [63:0]      mul_stage [MUL_LAT-1];
  logic [31:0]      div_a_mag;
  logic [31:0]      div_b_mag;
  logic [31:0]      div_q_mag;
  logic [31:0]      div_r_mag;
  logic [31:0]      div_q_fix;
  logic [31:0]      div_r_fix;
  logic             div_done;

  assign md_allowin_o = (state == ST_IDLE) || ((state == ST_DONE) && ms_allowin_i);
  assign accept       = md_valid_i && md_allowin_o && !md_flush_i;

  assign op_mul    = (md_op_i == MD_MULT) || (md_op_i == MD_MULTU);
  assign op_div    = (md_op_i == MD_DIV)  || (md_op_i == MD_DIVU);
  assign op_signed = (md_op_i == MD_MULT) || (md_op_i == MD_DIV);

  // Extending both operands to 64 bits (sign or zero) makes the low 64 bits
  // of an unsigned product correct for both MULT and MULTU.
  assign mul_a    = {{32{op_signed & md_src_a_i[31]}}, md_src_a_i};
  assign mul_b    = {{32{op_signed & md_src_b_i[31]}}, md_src_b_i};
  assign mul_prod = mul_a * mul_b;

  // Stage 0 captures the product at accept and then holds; later stages
  // shift so the last one carries it when the MUL state expires.
  always_ff @(posedge clk) begin
    if (accept && op_mul) mul_stage[0] <= mul_prod;
  end

  for (genvar g = 1; g < MUL_LAT - 1; g++) begin : g_mul_pipe
    always_ff @(posedge clk) begin
      mul_stage[g] <= mul_stage[g-1];
    end
  end

  assign div_a_mag = (op_signed && md_src_a_i[31]) ? (~md_src_a_i + 32'd1) : md_src_a_i;
  assign div_b_mag = (op_signed && md_src_b_i[31]) ? (~md_src_b_i + 32'd1) : md_src_b_i;

  md_div_iter u_div (
    .clk           (clk),
    .resetn        (resetn),
    .start         (accept && op_div),
    .kill          (md_flush_i),
    .dividend_mag  (div_a_mag),
    .divisor_mag   (div_b_mag),
    .quotient_mag  (div_q_mag),
    .remainder_mag (div_r_mag),
    .done          (div_done)
  );

  assign div_q_fix = div_neg_q ? (~div_q_mag + 32'd1) : div_q_mag;
  assign div_r_fix = div_neg_r ? (~div_r_mag + 32'd1) : div_r_mag;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      hi             <= '0;
      lo             <= '0;
      mul_cnt        <= '0;
      div_neg_q      <= 1'b0;
      div_neg_r      <= 1'b0;
      md_valid_o     <= 1'b0;
      md_result_o    <= '0;
      md_rd_o        <= '0;
      md_reg_write_o <= 1'b0;
      md_busy_o      <= 1'b0;
    end else if (md_flush_i) begin
      state          <= ST_IDLE;
      md_valid_o     <= 1'b0;
      md_busy_o      <= 1'b0;
      md_reg_write_o <= 1'b0;
    end else begin
      case (state)
        ST_MUL: begin
          if (mul_cnt == '0) begin
            hi         <= mul_stage[MUL_LAT-2][63:32];
            lo         <= mul_stage[MUL_LAT-2][31:0];
            state      <= ST_DONE;
            md_valid_o <= 1'b1;
            md_busy_o  <= 1'b0;
          end else begin
            mul_cnt <= mul_cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            lo         <= div_q_fix;
            hi         <= div_r_fix;
            state      <= ST_DONE;
            md_valid_o <= 1'b1;
            md_busy_o  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (ms_allowin_i) begin
            state      <= ST_IDLE;
            md_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase

      // A new accept overrides the DONE->IDLE retirement above (back-to-back).
      if (accept) begin
        state          <= ST_DONE;
        md_valid_o     <= 1'b1;
        md_busy_o      <= 1'b0;
        md_result_o    <= '0;
        md_rd_o        <= md_rd_i;
        md_reg_write_o <= 1'b0;
        case (md_op_i)
          MD_MULT, MD_MULTU: begin
            state      <= ST_MUL;
            md_valid_o <= 1'b0;
            md_busy_o  <= 1'b1;
            mul_cnt    <= CNT_W'(MUL_LAT - 2);
          end
          MD_DIV, MD_DIVU: begin
            state      <= ST_DIV;
            md_valid_o <= 1'b0;
            md_busy_o  <= 1'b1;
            div_neg_q  <= op_signed & (md_src_a_i[31] ^ md_src_b_i[31]);
            div_neg_r  <= op_signed & md_src_a_i[31];
          end
          MD_MFHI: begin
            md_result_o    <= hi;
            md_reg_write_o <= |md_rd_i;
          end
          MD_MFLO: begin
            md_result_o    <= lo;
            md_reg_write_o <= |md_rd_i;
          end
          MD_MTHI: hi <= md_src_a_i;
          MD_MTLO: lo <= md_src_a_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a driver issues operations and pushes
// the expected record (value, rd, reg_write, first-valid cycle) computed by
// an operation-level HI/LO model; a monitor compares every valid cycle.
module tb_muldiv_unit;

  localparam int unsigned LAT = 3;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk;
  logic        resetn;
  logic        md_valid_i;
  logic [3:0]  md_op_i;
  logic [31:0] md_src_a_i;
  logic [31:0] md_src_b_i;
  logic [4:0]  md_rd_i;
  logic        md_allowin_o;
  logic        md_flush_i;
  logic        ms_allowin_i;
  logic        md_valid_o;
  logic [31:0] md_result_o;
  logic [4:0]  md_rd_o;
  logic        md_reg_write_o;
  logic        md_busy_o;

  muldiv_unit #(.MUL_LAT(LAT)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .md_valid_i     (md_valid_i),
    .md_op_i        (md_op_i),
    .md_src_a_i     (md_src_a_i),
    .md_src_b_i     (md_src_b_i),
    .md_rd_i        (md_rd_i),
    .md_allowin_o   (md_allowin_o),
    .md_flush_i     (md_flush_i),
    .ms_allowin_i   (ms_allowin_i),
    .md_valid_o     (md_valid_o),
    .md_result_o    (md_result_o),
    .md_rd_o        (md_rd_o),
    .md_reg_write_o (md_reg_write_o),
    .md_busy_o      (md_busy_o)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    int          exp_cyc;
  } rec_t;

  rec_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] sv_hi = '0;
  logic [31:0] sv_lo = '0;
  int          pend_exp = -1;
  int          busy_from = 1;
  int          busy_to = 0;
  int          first_seen = -1;
  int          ms_mode = 1;
  int          hold_ms = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready pattern.
  always @(negedge clk) begin
    if (hold_ms > 0) begin
      ms_allowin_i = 1'b0;
      hold_ms--;
    end else if (ms_mode == 1) begin
      ms_allowin_i = 1'b1;
    end else begin
      ms_allowin_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares the presented record against the scoreboard head.
  always @(negedge clk) begin
    #2;
    chk("busy", {31'b0, md_busy_o}, {31'b0, (cyc >= busy_from) && (cyc <= busy_to)});
    if (md_valid_o) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got result %h rd %0d with empty scoreboard (cycle %0d)",
                 md_result_o, md_rd_o, cyc);
      end else begin
        if (first_seen < 0) begin
          first_seen = cyc;
          chk("valid_cycle", 32'(cyc), 32'(sbq[0].exp_cyc));
        end
        chk("result", md_result_o, sbq[0].result);
        chk("rd", {27'b0, md_rd_o}, {27'b0, sbq[0].rd});
        chk("reg_write", {31'b0, md_reg_write_o}, {31'b0, sbq[0].rw});
        if (ms_allowin_i && !md_flush_i) begin
          void'(sbq.pop_front());
          first_seen = -1;
        end
      end
    end
  end

  // Operation-level reference: HI/LO effects applied at accept time.
  function automatic void model_accept(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd,
                                       input bit use_exp, input logic [31:0] exp, input int n);
    logic [63:0] p;
    logic [31:0] q, r, res;
    longint      la, lb;
    int          sa, sb, lat;
    logic        rw;
    res = '0;
    lat = 1;
    q   = '0;
    r   = '0;
    p   = '0;
    case (op)
      OP_MULT, OP_MULTU: begin
        if (op == OP_MULT) begin
          la = longint'($signed(a));
          lb = longint'($signed(b));
          p  = la * lb;
        end else begin
          p = {32'b0, a} * {32'b0, b};
        end
        sv_hi = m_hi; sv_lo = m_lo;
        m_hi = p[63:32]; m_lo = p[31:0];
        lat = int'(LAT);
      end
      OP_DIV, OP_DIVU: begin
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
          q = (op == OP_DIV && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
          r = a;
        end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = 32'd0;
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = a / b;
          r = a % b;
        end
        sv_hi = m_hi; sv_lo = m_lo;
        m_lo = q; m_hi = r;
        lat = 33;
      end
      OP_MFHI: res = m_hi;
      OP_MFLO: res = m_lo;
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
    if (lat > 1) begin
      pend_exp  = n + lat;
      busy_from = n + 1;
      busy_to   = n + lat - 1;
    end
    if (use_exp) res = exp;
    rw = ((op == OP_MFHI) || (op == OP_MFLO)) && (rd != 5'd0);
    sbq.push_back('{result: res, rd: rd, rw: rw, exp_cyc: n + lat});
  endfunction

  function automatic void model_flush(input int c);
    if (c < pend_exp) begin
      m_hi = sv_hi;
      m_lo = sv_lo;
    end
    pend_exp = -1;
    sbq.delete();
    first_seen = -1;
    if (busy_to > c) busy_to = c;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit use_exp, input logic [31:0] exp,
                       output int waited);
    bit done;
    done   = 0;
    waited = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      md_valid_i = 1'b1;
      md_op_i    = op;
      md_src_a_i = a;
      md_src_b_i = b;
      md_rd_i    = rd;
      md_flush_i = 1'b0;
      #1;
      if (md_allowin_o) begin
        model_accept(op, a, b, rd, use_exp, exp, cyc);
        done = 1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      md_valid_i = 1'b0;
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept for op %0d expected accept within 300 cycles", op);
    end
    @(posedge clk);
    #1;
    md_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    int c;
    @(negedge clk);
    md_valid_i = 1'b0;
    md_flush_i = 1'b1;
    c = cyc;
    @(posedge clk);
    #1;
    md_flush_i = 1'b0;
    model_flush(c);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int w;
    resetn       = 1'b0;
    md_valid_i   = 1'b0;
    md_op_i      = OP_NOP;
    md_src_a_i   = '0;
    md_src_b_i   = '0;
    md_rd_i      = '0;
    md_flush_i   = 1'b0;
    ms_allowin_i = 1'b1;
    #2;
    chk("rst_valid", {31'b0, md_valid_o}, 32'd0);
    chk("rst_result", md_result_o, 32'd0);
    chk("rst_rd", {27'b0, md_rd_o}, 32'd0);
    chk("rst_reg_write", {31'b0, md_reg_write_o}, 32'd0);
    chk("rst_busy", {31'b0, md_busy_o}, 32'd0);
    chk("rst_allowin", {31'b0, md_allowin_o}, 32'd1);
    #20;
    resetn = 1'b1;

    // MT/MF round trip, back-to-back.
    issue(OP_MTHI, 32'h1234_5678, 32'd0, 5'd0, 0, '0, w);
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0, 5'd0, 0, '0, w);
    issue(OP_MFHI, 32'd0, 32'd0, 5'd2, 1, 32'h1234_5678, w);
    chk("mf_b2b_wait", 32'(w), 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd3, 1, 32'h9ABC_DEF0, w);
    chk("mf_b2b_wait2", 32'(w), 32'd0);

    // Multiplies.
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 5'd1, 0, '0, w);
    issue(OP_MFHI, 32'd0, 32'd0, 5'd4, 1, 32'hFFFF_FFFF, w);
    chk("mult_wait", 32'(w), 32'(LAT - 1));
    issue(OP_MFLO, 32'd0, 32'd0, 5'd4, 1, 32'hFFFF_FFFA, w);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5'd0, 0, '0, w);
    issue(OP_MFHI, 32'd0, 32'd0, 5'd4, 1, 32'h0000_0002, w);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd0, 1, 32'hFFFF_FFFA, w);

    // Divides, including divide-by-zero and overflow.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 0, '0, w);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd5, 1, 32'hFFFF_FFFD, w);
    chk("div_wait", 32'(w), 32'd32);
    issue(OP_MFHI, 32'd0, 32'd0, 5'd5, 1, 32'hFFFF_FFFF, w);
    issue(OP_DIVU, 32'd7, 32'd0, 5'd0, 0, '0, w);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd6, 1, 32'hFFFF_FFFF, w);
    issue(OP_MFHI, 32'd0, 32'd0, 5'd6, 1, 32'd7, w);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, '0, w);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd7, 1, 32'h8000_0000, w);
    issue(OP_MFHI, 32'd0, 32'd0, 5'd7, 1, 32'd0, w);

    // Flush in the middle of a divide (step 10).
    issue(OP_MTHI, 32'h55, 32'd0, 5'd0, 0, '0, w);
    issue(OP_MTLO, 32'h55, 32'd0, 5'd0, 0, '0, w);
    issue(OP_DIV, 32'd100, 32'd7, 5'd0, 0, '0, w);
    repeat (10) @(negedge clk);
    do_flush();
    chk("flush_valid", {31'b0, md_valid_o}, 32'd0);
    chk("flush_busy", {31'b0, md_busy_o}, 32'd0);
    chk("flush_idle_allowin", {31'b0, md_allowin_o}, 32'd1);
    issue(OP_MFHI, 32'd0, 32'd0, 5'd8, 1, 32'h55, w);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd8, 1, 32'h55, w);

    // Downstream stall in DONE with the next op waiting.
    issue(OP_MFHI, 32'd0, 32'd0, 5'd10, 1, 32'h55, w);
    hold_ms = 5;
    issue(OP_MTLO, 32'hCAFE_0001, 32'd0, 5'd11, 0, '0, w);
    chk("stall_wait", 32'(w), 32'd5);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd12, 1, 32'hCAFE_0001, w);
    drain();

    // Randomized traffic with random downstream stalls and occasional flushes.
    ms_mode = 0;
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 29);
      if (sel == 0) begin
        do_flush();
      end else if (sel < 3) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end else begin
        issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 5'($urandom_range(0, 31)), 0, '0, w);
      end
    end
    ms_mode = 1;
    drain();

    // Asynchronous reset while a multiply is in flight.
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 5'd0, 0, '0, w);
    issue(OP_MULT, 32'd5, 32'd6, 5'd7, 0, '0, w);
    #2;
    resetn = 1'b0;
    #1;
    chk("amid_valid", {31'b0, md_valid_o}, 32'd0);
    chk("amid_result", md_result_o, 32'd0);
    chk("amid_rd", {27'b0, md_rd_o}, 32'd0);
    chk("amid_reg_write", {31'b0, md_reg_write_o}, 32'd0);
    chk("amid_busy", {31'b0, md_busy_o}, 32'd0);
    chk("amid_allowin", {31'b0, md_allowin_o}, 32'd1);
    m_hi = '0;
    m_lo = '0;
    sbq.delete();
    pend_exp   = -1;
    busy_from  = 1;
    busy_to    = 0;
    first_seen = -1;
    @(negedge clk);
    @(negedge clk);
    #3;
    resetn = 1'b1;
    issue(OP_MFHI, 32'd0, 32'd0, 5'd13, 1, 32'd0, w);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd14, 1, 32'd0, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the complex execute lane, directly downstream of the issue stage's complex bus. It accepts one MIPS HI/LO-class operation per handshake, owns the architectural HI/LO registers, and runs MULT/MULTU with fixed latency and DIV/DIVU as a 32-step radix-2 divider. It hands MFHI/MFLO results to the next stage with a valid/allowin handshake.

## Interface
- `MUL_LAT`, default 2: cycles from accept to result valid for MULT/MULTU. Must be at least 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `md_valid_i` in 1: operation offered by the issue stage.
- `md_op_i` in 4: operation code.
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
  - Codes 9–15 are treated as NOP.
- `md_src_a_i` in 32: rs value (dividend / multiplicand / MT source).
- `md_src_b_i` in 32: rt value (divisor / multiplier).
- `md_rd_i` in 5: destination register for MFHI/MFLO.
- `md_allowin_o` out 1: unit can accept this cycle.
- `md_flush_i` in 1: exception/ERET flush.
- `ms_allowin_i` in 1: downstream stage accepts a result.
- `md_valid_o` out 1: result/record valid to downstream.
- `md_result_o` out 32: MFHI/MFLO data; 0 for all other ops.
- `md_rd_o` out 5: destination register.
- `md_reg_write_o` out 1: high only for MFHI/MFLO with rd≠0.
- `md_busy_o` out 1: high in the MUL or DIV state.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- Accept condition: `md_valid_i && md_allowin_o && !md_flush_i`.
- `md_allowin_o = (state==IDLE) || (state==DONE && ms_allowin_i)`.
- On accept:
  - MF/MT/NOP → DONE.
  - MULT/MULTU → MUL, latency counter loaded.
  - DIV/DIVU → DIV, step counter = 0.
- MTHI/MTLO write HI/LO at the accept edge.
- MFHI/MFLO sample HI/LO at the accept edge. Ops are in order, so a preceding MULT/DIV has always completed.
- MULT: signed 32×32→64. MULTU: unsigned. On the MUL→DONE edge, HI = product[63:32] and LO = product[31:0].
- DIV/DIVU use a restoring algorithm on magnitudes.
  - DIV: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - On the DIV→DONE edge, LO = quotient and HI = remainder.
  - Divide by zero: LO = 0xFFFFFFFF magnitude-result before sign fix, HI = dividend (signed sign rules still apply). The result is deterministic and no exception is raised.
  - 0x80000000 / −1 (DIV): LO = 0x80000000, HI = 0.
- DONE holds `md_valid_o` = 1 until `ms_allowin_i`.
  - Same cycle with no new accept → IDLE.
  - Same cycle with a new accept → the new op's next state (back-to-back).
- Flush has priority over everything.
  - Any state → IDLE next edge; `md_valid_o` = 0; the aborted MUL/DIV never writes HI/LO.
  - HI/LO writes already committed (MT, completed MUL/DIV) are kept.
- Reset values:
  - state IDLE; HI = LO = 0.
  - `md_valid_o` = 0, `md_result_o` = 0, `md_rd_o` = 0, `md_reg_write_o` = 0, `md_busy_o` = 0.
  - `md_allowin_o` = 1.

## Timing
Accept at edge ending cycle N.
- MF/MT/NOP: `md_valid_o` in N+1.
- MULT/MULTU: state MUL in N+1..N+MUL_LAT−1; valid in N+MUL_LAT.
- DIV/DIVU: state DIV in N+1..N+32 (one quotient bit per cycle, counter 0..31); valid in N+33.
- Throughput: one op per cycle when downstream never stalls and ops are MF/MT.
- `md_allowin_o` is combinational from `ms_allowin_i`. There is no path from `md_valid_i` to any output.
- Reset assertion mid-DIV returns to IDLE asynchronously and clears HI/LO.

## Structure
- Shared package `muldiv_pkg`:
  - op code localparams (MD_NOP..MD_MTLO);
  - state encoding (2 bits);
  - `DIV_STEPS` = 32.
- Sub-module `md_div_iter`: radix-2 restoring divider datapath.
  - Inputs: start, magnitudes.
  - Outputs: quotient/remainder magnitudes, done.
  - The FSM, sign fix-up and HI/LO stay in `muldiv_unit`.
- Multiplier is an inferred `*` registered through a `MUL_LAT`−1 stage shift chain.

## Test plan
- MTHI 0x12345678, MTLO 0x9ABCDEF0, then MFHI rd=2, MFLO rd=3 → results 0x12345678 and 0x9ABCDEF0 in consecutive cycles with reg_write = 1.
- MULT 0xFFFFFFFE × 3, then MFHI/MFLO → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, first MF valid 1 cycle after the MULT record's DONE cycle. MULTU same operands → HI = 0x2, LO = 0xFFFFFFFA.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, valid exactly 33 cycles after accept. DIVU 7/0 → LO = 0xFFFFFFFF, HI = 7.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Flush asserted at DIV step 10 with HI = LO = 0x55 beforehand → IDLE next cycle, no valid output, MFHI afterwards returns 0x55.
- Hold `ms_allowin_i` = 0 for 5 cycles in DONE with a new op offered → `md_valid_o` and `md_result_o` stable; new op accepted in the same cycle `ms_allowin_i` rises. Reset mid-MUL → all outputs at reset values immediately.
